// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx_pkg
// Shared definitions for the serial word transmitter and the receiver-side
// divisibility checkers: state encoding, remainder width and the mod-3
// single-bit step used by mod3_acc.
package serial_word_tx_pkg;

   localparam int REM_W = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SHIFT  = 2'd1;
   localparam state_t ST_PARITY = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   // One remainder step for a single incoming bit b.
   //   dbl=1 : (2*rem + b) mod 3        (MSB-first stream)
   //   dbl=0 : (rem + b*weight) mod 3   (LSB-first stream, weight 1 or 2)
   // The unreduced sum never exceeds 5, so one conditional subtract suffices.
   function automatic logic [REM_W-1:0] mod3_step(input logic [REM_W-1:0] rem,
                                                  input logic             b,
                                                  input logic [1:0]       weight,
                                                  input logic             dbl);
      logic [2:0] sum;
      if (dbl)
         sum = {rem, 1'b0} + {2'b00, b};
      else
         sum = {1'b0, rem} + (b ? {1'b0, weight} : 3'd0);
      if (sum >= 3'd3)
         sum = sum - 3'd3;
      return sum[REM_W-1:0];
   endfunction

endpackage

// File: rtl/serial_word_tx_mod3_acc.sv
// mod3_acc
// Running remainder mod 3 of a serial bit stream. Reusable on the receive
// side of the serial bit-stream interface.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clr            restart the remainder at 0 (priority over en)
//   en             fold bit b into the remainder this edge
//   b              incoming bit
//   weight         2'd1 / 2'd2 positional weight (LSB-first mode only)
//   rem            current remainder, always 0..2
module mod3_acc
   import serial_word_tx_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             b,
   input  logic [1:0]       weight,
   output logic [REM_W-1:0] rem
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         rem <= '0;
      else if (en)
         rem <= mod3_step(rem, b, weight, MSB_FIRST);
   end

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx
// Parallel-to-serial transmitter: takes a W-bit word over valid/ready and
// emits it one bit per clock, tracking the remainder mod 3 of the bits sent.
// A one-cycle done pulse reports the final remainder and a divisible-by-3 flag.
// Optional build macro PARITY_BIT_EN appends an even-parity bit after the
// last data bit (not folded into the remainder).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  word handshake (ready only in IDLE)
//   in_data            word, sampled at acceptance only
//   bit_out/bit_valid  serial bit and its qualifier
//   first_bit/last_bit markers for the first/last data bit
//   rem_out            remainder of bits sent so far (lags the bit by a cycle)
//   done/div3          completion pulse and divisible-by-3 flag
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | ready for a word, rem_out holds the last result
// ST_SHIFT   | one data bit per cycle, cnt = index 0..W-1
// ST_PARITY  | even-parity bit of the word (PARITY_BIT_EN only)
// ST_DONE    | one-cycle done pulse with final remainder
module serial_word_tx
   import serial_word_tx_pkg::*;
#(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             first_bit,
   output logic             last_bit,
   output logic [REM_W-1:0] rem_out,
   output logic             done,
   output logic             div3
);

   localparam int               CNT_W    = $clog2(W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   state_t           state;
   logic [W-1:0]     shreg;
   logic [CNT_W-1:0] cnt;
   logic             cur_bit;
   logic             accept;
   logic             acc_en;
   logic [1:0]       acc_weight;
   logic [REM_W-1:0] rem;
`ifdef PARITY_BIT_EN
   logic             par;
`endif

   assign accept     = (state == ST_IDLE) && in_valid;
   assign cur_bit    = MSB_FIRST ? shreg[W-1] : shreg[0];
   assign acc_en     = (state == ST_SHIFT);
   // LSB-first: bit index == cnt, odd indices carry weight 2 (2^odd mod 3).
   assign acc_weight = cnt[0] ? 2'd2 : 2'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef PARITY_BIT_EN
         par   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  shreg <= in_data;
                  cnt   <= '0;
`ifdef PARITY_BIT_EN
                  par   <= 1'b0;
`endif
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (MSB_FIRST)
                  shreg <= {shreg[W-2:0], 1'b0};
               else
                  shreg <= {1'b0, shreg[W-1:1]};
               cnt <= cnt + CNT_W'(1);
`ifdef PARITY_BIT_EN
               par <= par ^ cur_bit;
`endif
               if (cnt == CNT_LAST) begin
`ifdef PARITY_BIT_EN
                  state <= ST_PARITY;
`else
                  state <= ST_DONE;
`endif
               end
            end
`ifdef PARITY_BIT_EN
            ST_PARITY: state <= ST_DONE;
`endif
            ST_DONE:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   mod3_acc #(.MSB_FIRST(MSB_FIRST)) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .en     (acc_en),
      .b      (cur_bit),
      .weight (acc_weight),
      .rem    (rem)
   );

   // Outputs decode only registered state; bit_out is forced low when idle.
   assign in_ready  = (state == ST_IDLE);
`ifdef PARITY_BIT_EN
   assign bit_valid = (state == ST_SHIFT) || (state == ST_PARITY);
   assign bit_out   = ((state == ST_SHIFT) && cur_bit) || ((state == ST_PARITY) && par);
`else
   assign bit_valid = (state == ST_SHIFT);
   assign bit_out   = (state == ST_SHIFT) && cur_bit;
`endif
   assign first_bit = (state == ST_SHIFT) && (cnt == '0);
   assign last_bit  = (state == ST_SHIFT) && (cnt == CNT_LAST);
   assign rem_out   = rem;
   assign done      = (state == ST_DONE);
   assign div3      = (state == ST_DONE) && (rem == '0);

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

   localparam int W = 8;
`ifdef PARITY_BIT_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int DP = W + 1 + PB;   // cycles from acceptance edge to done

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] in_data;

   logic       m_ready, m_bit, m_bv, m_first, m_last, m_done, m_div3;
   logic [1:0] m_rem;
   logic       l_ready, l_bit, l_bv, l_first, l_last, l_done, l_div3;
   logic [1:0] l_rem;

   int checks   = 0;
   int failures = 0;

   serial_word_tx #(.W(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_ready),
      .in_data(in_data), .bit_out(m_bit), .bit_valid(m_bv),
      .first_bit(m_first), .last_bit(m_last), .rem_out(m_rem),
      .done(m_done), .div3(m_div3)
   );

   serial_word_tx #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_ready),
      .in_data(in_data), .bit_out(l_bit), .bit_valid(l_bv),
      .first_bit(l_first), .last_bit(l_last), .rem_out(l_rem),
      .done(l_done), .div3(l_div3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Remainder of the first k transmitted bits, computed as the numeric value
   // those bits form in the stream order.
   function automatic int prefix_rem(input logic [W-1:0] w, input int k, input bit msb);
      int v;
      if (k == 0) return 0;
      if (msb) v = int'(w) >> (W - k);
      else     v = int'(w) & ((1 << k) - 1);
      return v % 3;
   endfunction

   // Model: ph = 0 idle, otherwise cycles since the acceptance edge (1..DP).
   int           ph = 0;
   int           hold = 0;
   bit           started = 0;
   logic [W-1:0] mw = '0;

   task automatic cmp_dut(input string tag, input bit msb,
                          input logic ready, input logic bv, input logic bo,
                          input logic first, input logic last, input logic dn,
                          input logic d3, input logic [1:0] rem);
      int e_bv, e_bo, e_rem, fin;
      fin   = int'(mw) % 3;
      e_bv  = 0;
      e_bo  = 0;
      e_rem = hold;
      if (ph >= 1 && ph <= W) begin
         e_bv  = 1;
         e_bo  = msb ? int'(mw[W-ph]) : int'(mw[ph-1]);
         e_rem = prefix_rem(mw, ph - 1, msb);
      end else if (ph > W) begin
         e_rem = fin;
         if (PB == 1 && ph == W + 1) begin
            e_bv = 1;
            e_bo = int'(^mw);
         end
      end
      chk({tag, "_ready"}, int'(ready), int'(ph == 0));
      chk({tag, "_valid"}, int'(bv), e_bv);
      chk({tag, "_bit"},   int'(bo), e_bo);
      chk({tag, "_first"}, int'(first), int'(ph == 1));
      chk({tag, "_last"},  int'(last), int'(ph == W));
      chk({tag, "_done"},  int'(dn), int'(ph == DP));
      chk({tag, "_div3"},  int'(d3), int'(ph == DP && fin == 0));
      chk({tag, "_rem"},   int'(rem), e_rem);
   endtask

   always @(posedge clk) begin
      if (reset) begin
         ph      = 0;
         hold    = 0;
         started = 1;
      end else if (ph == 0) begin
         if (in_valid) begin
            mw = in_data;
            ph = 1;
         end
      end else if (ph == DP) begin
         ph   = 0;
         hold = int'(mw) % 3;
      end else begin
         ph++;
      end
      #2;
      if (started) begin
         cmp_dut("msb", 1'b1, m_ready, m_bv, m_bit, m_first, m_last, m_done, m_div3, m_rem);
         cmp_dut("lsb", 1'b0, l_ready, l_bv, l_bit, l_first, l_last, l_done, l_div3, l_rem);
      end
   end

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   int t1_bits[8] = '{0, 1, 1, 1, 0, 0, 1, 1};
   int t1_rem[8]  = '{0, 1, 0, 1, 2, 1, 0, 1};
   int t3_bits[8] = '{1, 1, 0, 0, 1, 1, 1, 0};

   initial begin
      // reset with in_valid high: reset must win
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      step();
      step();
      chk("rst_ready", int'(m_ready), 1);
      chk("rst_valid", int'(m_bv), 0);
      chk("rst_bit",   int'(m_bit), 0);
      chk("rst_rem",   int'(m_rem), 0);
      chk("rst_done",  int'(m_done), 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      step();

      // word 115 on both stream orders
      in_data  = 8'b0111_0011;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_first", int'(m_first), 1);
      for (int k = 0; k < W; k++) begin
         chk("t1_bit", int'(m_bit), t1_bits[k]);
         chk("t3_bit", int'(l_bit), t3_bits[k]);
         if (k == W - 1) chk("t1_last", int'(m_last), 1);
         step();
         chk("t1_rem", int'(m_rem), t1_rem[k]);
      end
`ifdef PARITY_BIT_EN
      chk("t6_pbit",  int'(m_bit), 1);
      chk("t6_pval",  int'(m_bv), 1);
      chk("t6_plast", int'(m_last), 0);
      step();
`endif
      chk("t1_done", int'(m_done), 1);
      chk("t1_frem", int'(m_rem), 1);
      chk("t1_div3", int'(m_div3), 0);
      chk("t3_frem", int'(l_rem), 1);
      chk("t3_div3", int'(l_div3), 0);
      step();
      chk("t1_hold", int'(m_rem), 1);

      // FF then 00 with in_valid held high
      in_data  = 8'hFF;
      in_valid = 1'b1;
      step();
      in_data  = 8'h00;
      repeat (DP - 1) step();
      chk("t2a_done", int'(m_done), 1);
      chk("t2a_rem",  int'(m_rem), 0);
      chk("t2a_div3", int'(m_div3), 1);
      step();
      chk("t2_reacc_ready", int'(m_ready), 1);
      step();
      in_valid = 1'b0;
      chk("t2b_first", int'(m_first), 1);
      chk("t2b_bit",   int'(m_bit), 0);
      repeat (DP - 1) step();
      chk("t2b_done", int'(m_done), 1);
      chk("t2b_rem",  int'(m_rem), 0);
      chk("t2b_div3", int'(m_div3), 1);
      step();

      // reset during the 4th bit
      in_data  = 8'hA5;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      chk("t4_mid_valid", int'(m_bv), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t4_ready", int'(m_ready), 1);
      chk("t4_valid", int'(m_bv), 0);
      chk("t4_rem",   int'(m_rem), 0);
      for (int i = 0; i < 12; i++) begin
         chk("t4_nodone", int'(m_done), 0);
         step();
      end
      in_data  = 8'h2D;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (DP - 1) step();
      chk("t4_done", int'(m_done), 1);
      chk("t4_rem",  int'(m_rem), 0);
      chk("t4_div3", int'(m_div3), 1);
      step();

      // in_valid pulses during SHIFT and DONE are ignored
      in_data  = 8'h5A;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      in_data  = 8'hFF;
      in_valid = 1'b1;
      chk("t5_shift_ready", int'(m_ready), 0);
      step();
      in_valid = 1'b0;
      repeat (DP - 3) step();
      chk("t5_done", int'(m_done), 1);
      in_valid = 1'b1;
      chk("t5_done_ready", int'(m_ready), 0);
      chk("t5_rem", int'(m_rem), 0);
      step();
      in_valid = 1'b0;
      chk("t5_idle_ready", int'(m_ready), 1);
      step();
      chk("t5_noaccept_ready", int'(m_ready), 1);
      chk("t5_noaccept_valid", int'(m_bv), 0);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
